// File: rtl/flow_merge_pkg.sv
// Shared types and widths for the tagged flow merger.
package flow_merge_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned FLUX   = 4;
    localparam int unsigned TAG_W  = $clog2(FLUX);
    localparam int unsigned CNT_W  = 13;

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } flow_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } tagged_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            valid_o
);

    always_comb begin
        int unsigned k;
        k         = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[k]) begin
                valid_o   = 1'b1;
                gnt_o[k]  = 1'b1;
                gnt_idx_o = IdxW'(k);
            end
        end
    end

endmodule

// File: rtl/tagged_flow_merger.sv
// Merges per-flow show-ahead FIFOs into one tagged write stream with per-flow
// frame length tracking and frame completion pulses.
module tagged_flow_merger
    import flow_merge_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [FLUX*DATA_W-1:0]    src_data_i,
    input  logic [FLUX-1:0]           src_empty_i,
    output logic [FLUX-1:0]           src_read_o,
    input  logic [TAG_W+CNT_W-1:0]    cfg_din_i,
    input  logic                      cfg_write_i,
    output logic [TAG_W+DATA_W-1:0]   out_din_o,
    output logic                      out_write_o,
    input  logic [FLUX-1:0]           out_full_i,
    output logic [FLUX-1:0]           frame_done_o,
    output logic [FLUX-1:0]           busy_o,
    output logic [FLUX-1:0]           cfg_err_o
);

    flow_state_e        state_q [FLUX];
    flow_state_e        state_d [FLUX];
    logic [CNT_W-1:0]   rem_q   [FLUX];
    logic [CNT_W-1:0]   rem_d   [FLUX];
    logic [TAG_W-1:0]   ptr_q, ptr_d;
    tagged_word_t       out_q, out_d;
    logic               out_write_q;
    logic [FLUX-1:0]    done_q, done_d;
    logic [FLUX-1:0]    cfg_err_q, cfg_err_d;
    logic [FLUX-1:0]    eligible, gnt;
    logic [TAG_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic [TAG_W-1:0]   cfg_tag;
    logic [CNT_W-1:0]   cfg_len;

    assign cfg_tag = cfg_din_i[TAG_W+CNT_W-1 -: TAG_W];
    assign cfg_len = cfg_din_i[CNT_W-1:0];

    // Gating with reset keeps src_read low while rst is asserted.
    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            eligible[f] = !rst_i && (state_q[f] == StActive) && !src_empty_i[f]
                          && !out_full_i[f];
        end
    end

    rr_arbiter #(
        .N    (FLUX),
        .IdxW (TAG_W)
    ) u_arb (
        .req_i     (eligible),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .valid_o   (gnt_valid)
    );

    assign src_read_o = gnt;

    always_comb begin
        logic completing;
        completing = 1'b0;
        done_d     = '0;
        cfg_err_d  = cfg_err_q;
        out_d      = out_q;
        ptr_d      = ptr_q;
        for (int f = 0; f < FLUX; f++) begin
            state_d[f] = state_q[f];
            rem_d[f]   = rem_q[f];
            completing = gnt[f] && (rem_q[f] == CNT_W'(1));
            if (gnt[f]) begin
                rem_d[f]   = rem_q[f] - CNT_W'(1);
                out_d.tag  = TAG_W'(f);
                out_d.data = src_data_i[f*DATA_W +: DATA_W];
                if (completing) begin
                    state_d[f] = StIdle;
                    done_d[f]  = 1'b1;
                end
            end
            // A config landing on the completing cycle chains the next frame directly.
            if (cfg_write_i && (cfg_tag == TAG_W'(f))) begin
                if ((cfg_len != '0) && ((state_q[f] == StIdle) || completing)) begin
                    state_d[f] = StActive;
                    rem_d[f]   = cfg_len;
                end else begin
                    cfg_err_d[f] = 1'b1;
                end
            end
        end
        if (gnt_valid) begin
            ptr_d = (gnt_idx == TAG_W'(FLUX - 1)) ? '0 : gnt_idx + TAG_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int f = 0; f < FLUX; f++) begin
                state_q[f] <= StIdle;
                rem_q[f]   <= '0;
            end
            ptr_q       <= '0;
            out_q       <= '0;
            out_write_q <= 1'b0;
            done_q      <= '0;
            cfg_err_q   <= '0;
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                state_q[f] <= state_d[f];
                rem_q[f]   <= rem_d[f];
            end
            ptr_q       <= ptr_d;
            out_q       <= out_d;
            out_write_q <= gnt_valid;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            busy_o[f] = (state_q[f] == StActive);
        end
    end

    assign out_din_o    = out_q;
    assign out_write_o  = out_write_q;
    assign frame_done_o = done_q;
    assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_tagged_flow_merger.sv
// Directed self-checking bench for tagged_flow_merger.
module tb_tagged_flow_merger;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] src_data;
    logic [3:0]  src_empty;
    logic [3:0]  src_read;
    logic [14:0] cfg_din;
    logic        cfg_write;
    logic [9:0]  out_din;
    logic        out_write;
    logic [3:0]  out_full;
    logic [3:0]  frame_done;
    logic [3:0]  busy;
    logic [3:0]  cfg_err;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [1:0] q_tag  [$];
    logic [7:0] q_data [$];
    logic [3:0] q_done [$];
    int         q_cyc  [$];

    always #5 clk = ~clk;

    tagged_flow_merger dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .src_data_i   (src_data),
        .src_empty_i  (src_empty),
        .src_read_o   (src_read),
        .cfg_din_i    (cfg_din),
        .cfg_write_i  (cfg_write),
        .out_din_o    (out_din),
        .out_write_o  (out_write),
        .out_full_i   (out_full),
        .frame_done_o (frame_done),
        .busy_o       (busy),
        .cfg_err_o    (cfg_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (out_write === 1'b1) begin
            q_tag.push_back(out_din[9:8]);
            q_data.push_back(out_din[7:0]);
            q_done.push_back(frame_done);
            q_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_q();
        q_tag.delete();
        q_data.delete();
        q_done.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cfg_write = 1'b0;
        cfg_din   = '0;
        src_empty = 4'hF;
        out_full  = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        clear_q();
    endtask

    task automatic cfg(input int tag, input int len);
        cfg_din   = {tag[1:0], len[12:0]};
        cfg_write = 1'b1;
        tick();
        cfg_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if ({out_write, out_din, frame_done, busy, cfg_err, src_read} !== 27'd0) begin
            $display("FAIL reset_state got=%h want=0",
                     {out_write, out_din, frame_done, busy, cfg_err, src_read});
        end else passed++;
        total++;
    endtask

    task automatic test_single_flow();
        int c0;
        do_reset();
        src_data = 32'h0000_0011;
        cfg(0, 4);
        if (busy !== 4'b0001) $display("FAIL f0_busy_set got=%b want=0001", busy);
        else passed++;
        total++;
        src_empty = 4'b1110;
        #1;
        if (src_read !== 4'b0001) $display("FAIL f0_src_read got=%b want=0001", src_read);
        else passed++;
        total++;
        c0 = cyc;
        repeat (7) tick();
        if (q_tag.size() !== 4) $display("FAIL f0_count got=%0d want=4", q_tag.size());
        else passed++;
        total++;
        for (int i = 0; i < q_tag.size() && i < 4; i++) begin
            if ({q_tag[i], q_data[i], q_done[i]} !== {2'd0, 8'h11, (i == 3) ? 4'b0001 : 4'b0000}
                || q_cyc[i] !== c0 + 1 + i) begin
                $display("FAIL f0_word%0d got=%h/%h/%b@%0d want=0/11/%b@%0d", i, q_tag[i],
                         q_data[i], q_done[i], q_cyc[i], (i == 3) ? 4'b0001 : 4'b0000, c0 + 1 + i);
            end else passed++;
            total++;
        end
        if (busy !== 4'b0000) $display("FAIL f0_busy_clear got=%b want=0000", busy);
        else passed++;
        total++;
    endtask

    task automatic test_all_flows();
        do_reset();
        src_data = 32'hA3A2_A1A0;
        for (int f = 0; f < 4; f++) cfg(f, 3);
        src_empty = 4'h0;
        repeat (16) tick();
        if (q_tag.size() !== 12) $display("FAIL all_count got=%0d want=12", q_tag.size());
        else passed++;
        total++;
        for (int i = 0; i < q_tag.size() && i < 12; i++) begin
            logic [1:0] et;
            logic [7:0] ed;
            logic [3:0] edn;
            et  = 2'(i % 4);
            ed  = 8'hA0 + 8'(i % 4);
            edn = (i >= 8) ? 4'(1 << (i - 8)) : 4'b0000;
            if ({q_tag[i], q_data[i], q_done[i]} !== {et, ed, edn} || q_cyc[i] !== q_cyc[0] + i)
                $display("FAIL all_word%0d got=%h/%h/%b want=%h/%h/%b", i, q_tag[i], q_data[i],
                         q_done[i], et, ed, edn);
            else passed++;
            total++;
        end
    endtask

    task automatic test_full();
        int         exp_tag  [12] = '{0, 2, 3, 0, 2, 3, 0, 2, 3, 1, 1, 1};
        logic [3:0] exp_done [12] = '{0, 0, 0, 0, 0, 0, 1, 4, 8, 0, 0, 2};
        do_reset();
        src_data = 32'hA3A2_A1A0;
        for (int f = 0; f < 4; f++) cfg(f, 3);
        src_empty = 4'h0;
        out_full  = 4'b0010;
        repeat (8) tick();
        out_full = 4'b0000;
        repeat (8) tick();
        if (q_tag.size() !== 12) $display("FAIL full_count got=%0d want=12", q_tag.size());
        else passed++;
        total++;
        for (int i = 0; i < q_tag.size() && i < 12; i++) begin
            if (q_tag[i] !== 2'(exp_tag[i]) || q_done[i] !== exp_done[i]
                || q_data[i] !== 8'hA0 + 8'(exp_tag[i]))
                $display("FAIL full_word%0d got=%h/%h/%b want=%0d/%b", i, q_tag[i], q_data[i],
                         q_done[i], exp_tag[i], exp_done[i]);
            else passed++;
            total++;
        end
    endtask

    task automatic test_cfg_err();
        int n2;
        do_reset();
        src_data = 32'hA3A2_A1A0;
        cfg(2, 5);
        if (cfg_err !== 4'b0000) $display("FAIL err_first got=%b want=0000", cfg_err);
        else passed++;
        total++;
        cfg(2, 7);
        if (cfg_err !== 4'b0100) $display("FAIL err_active got=%b want=0100", cfg_err);
        else passed++;
        total++;
        cfg(3, 0);
        if ({cfg_err, busy} !== 8'b1100_0100)
            $display("FAIL err_zero got=%b/%b want=1100/0100", cfg_err, busy);
        else passed++;
        total++;
        src_empty = 4'h0;
        repeat (10) tick();
        n2 = 0;
        foreach (q_tag[i]) if (q_tag[i] === 2'd2) n2++;
        if (n2 !== 5 || q_tag.size() !== 5)
            $display("FAIL err_words got=%0d/%0d want=5/5", n2, q_tag.size());
        else passed++;
        total++;
        if (busy !== 4'b0000) $display("FAIL err_busy_end got=%b want=0000", busy);
        else passed++;
        total++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_done [5] = '{0, 0, 1, 0, 1};
        do_reset();
        src_data = 32'h0000_0055;
        cfg(0, 3);
        src_empty = 4'b1110;
        tick();
        tick();
        cfg_din   = {2'd0, 13'd2};
        cfg_write = 1'b1;
        tick();
        cfg_write = 1'b0;
        repeat (6) tick();
        if (q_tag.size() !== 5 || cfg_err !== 4'b0000)
            $display("FAIL b2b_count got=%0d err=%b want=5 err=0000", q_tag.size(), cfg_err);
        else passed++;
        total++;
        for (int i = 0; i < q_tag.size() && i < 5; i++) begin
            if ({q_tag[i], q_data[i], q_done[i]} !== {2'd0, 8'h55, exp_done[i]}
                || q_cyc[i] !== q_cyc[0] + i)
                $display("FAIL b2b_word%0d got=%h/%h/%b@%0d want=0/55/%b@%0d", i, q_tag[i],
                         q_data[i], q_done[i], q_cyc[i], exp_done[i], q_cyc[0] + i);
            else passed++;
            total++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        src_data = 32'hA3A2_A1A0;
        cfg(1, 8);
        src_empty = 4'b1101;
        tick();
        tick();
        rst = 1'b1;
        #1;
        if (src_read !== 4'b0000) $display("FAIL rst_src_read got=%b want=0000", src_read);
        else passed++;
        total++;
        tick();
        if ({out_write, busy, frame_done} !== 9'd0)
            $display("FAIL rst_mid got=%b/%b/%b want=0/0000/0000", out_write, busy, frame_done);
        else passed++;
        total++;
        rst       = 1'b0;
        src_empty = 4'hF;
        clear_q();
        cfg(3, 1);
        cfg(0, 1);
        src_empty = 4'h0;
        repeat (4) tick();
        if (q_tag.size() !== 2) $display("FAIL rst_post_count got=%0d want=2", q_tag.size());
        else passed++;
        total++;
        if (q_tag.size() >= 2) begin
            if ({q_tag[0], q_done[0], q_tag[1], q_done[1]} !== {2'd0, 4'b0001, 2'd3, 4'b1000})
                $display("FAIL rst_post_order got=%0d/%b,%0d/%b want=0/0001,3/1000",
                         q_tag[0], q_done[0], q_tag[1], q_done[1]);
            else passed++;
            total++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        src_data  = '0;
        src_empty = 4'hF;
        cfg_din   = '0;
        cfg_write = 1'b0;
        out_full  = 4'h0;
        test_reset();
        test_single_flow();
        test_all_flows();
        test_full();
        test_cfg_err();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tagged_flow_merger.md
Name: tagged_flow_merger

Overview:
- Output-side merger for the multi-flow filter accelerator.
- Collects results from FLUX per-flow output FIFOs (show-ahead read side).
- Round-robin arbitrates among them and emits a single tagged write stream: {flow tag, pixel}, with a write strobe and a per-flow full vector. This is the stream format the downstream consumer checks.
- Tracks a per-flow frame length and signals frame completion per flow.

Parameters:
- DATA_W, 8, pixel width
- FLUX, 4, number of concurrent flows
- TAG_W, $clog2(FLUX) = 2, flow tag width
- CNT_W, 13, frame length counter width (up to 71x71 words)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src_data  in  FLUX*DATA_W  per-flow FIFO head data; flow f occupies bits [f*DATA_W +: DATA_W]; valid while !src_empty[f]
- src_empty  in  FLUX  per-flow FIFO empty
- src_read  out  FLUX  per-flow FIFO pop, combinational, one-hot or zero
- cfg_din  in  TAG_W+CNT_W  {flow tag, frame length in words}
- cfg_write  in  1  configuration strobe
- out_din  out  TAG_W+DATA_W  {flow tag, pixel}, registered
- out_write  out  1  output write strobe, registered
- out_full  in  FLUX  per-flow downstream full
- frame_done  out  FLUX  one-cycle pulse, aligned with the last word's out_write
- busy  out  FLUX  flow is ACTIVE
- cfg_err  out  FLUX  sticky per-flow configuration error

Behaviour:
- Reset (synchronous, clk edge with rst=1): all flows IDLE; remaining counts 0; RR pointer 0; out_write 0; out_din 0; frame_done 0; cfg_err 0.
  - src_read is 0 while rst is high.
  - Reset mid-frame abandons the frame with no frame_done pulse.
- Per-flow FSM has two states, IDLE and ACTIVE.
  - IDLE -> ACTIVE on an accepted config for that flow; rem <= length.
  - ACTIVE -> IDLE when the word with rem==1 is granted.
- Config acceptance: cfg_write with tag f and length != 0 is accepted when flow f is IDLE, or ACTIVE and completing in the same cycle.
  - In the completing case the flow stays ACTIVE with rem <= new length, so frames run back-to-back.
  - Otherwise the config is ignored, cfg_err[f] <= 1 and rem is unchanged.
  - Length 0 is always rejected and sets cfg_err[f].
- Eligibility: flow f is eligible when ACTIVE && !src_empty[f] && !out_full[f].
- Arbitration:
  - Scan from ptr, ptr+1, ... mod FLUX; grant the first eligible flow.
  - At most one grant per cycle.
  - On a grant g, ptr <= (g+1) mod FLUX. With no grant, ptr holds.
- Grant cycle t:
  - src_read[g] = 1 in cycle t.
  - Cycle t+1: out_write = 1, out_din = {g, src_data[g] sampled at t}.
  - rem[g] decrements at t.
  - If rem was 1: frame_done[g] = 1 in t+1, busy[g] falls in t+1.
- Latency is 1 cycle from pop to out_write. Throughput is 1 word/cycle aggregate.
- Full handling:
  - out_full is sampled in the grant cycle only.
  - A word granted at t is written at t+1 regardless of out_full at t+1.
  - Consumer FIFOs must keep at least 1 free slot of margin after raising full.
- Width rules:
  - Tag is the granted index truncated to TAG_W.
  - rem is unsigned CNT_W; it never wraps because no grant is possible when rem==0 (flow is IDLE).
- Simultaneous events: config for flow f and a grant to flow h≠f in the same cycle are independent.

Decomposition:
- Package flow_merge_pkg contains:
  - the flow state enum (IDLE, ACTIVE);
  - TAG_W / CNT_W localparams;
  - a tagged-word struct {tag, data}.
- One sub-module, rr_arbiter:
  - parameter N;
  - inputs: req[N], ptr;
  - outputs: grant one-hot, grant index, valid;
  - purely combinational priority rotation.
- Counters, FSMs and the output register live in the top.

Test Plan:
- Flow 0 only, cfg {0,4}, src_data[0]=0x11 always non-empty -> 4 pops on consecutive cycles; out_din 0x011 x4 on consecutive cycles starting 1 cycle after the first pop; frame_done[0] with the 4th write; busy[0] 1->0.
- All 4 flows cfg length 3, all non-empty, data = 0xA0+f -> 12 back-to-back writes, tag order 0,1,2,3 repeated 3 times; frame_done[f] pulses on writes 9..12.
- As above with out_full[1]=1 for the first 8 cycles -> tags 0,2,3,0,2,3,... and no tag-1 write granted while full; after release flow 1 completes its 3 words; total 12 writes.
- cfg {2,5} then {2,7} while flow 2 is ACTIVE -> cfg_err[2]=1, exactly 5 flow-2 words written. cfg {3,0} -> cfg_err[3]=1, busy[3] stays 0.
- cfg {0,2} issued in the cycle of the last grant of a length-3 frame -> no idle gap; 5 consecutive tag-0 writes; frame_done[0] pulses after words 3 and 5.
- rst asserted for 1 cycle mid-frame (flow 1 at rem=6) -> next cycle out_write=0, busy=0, no frame_done; post-reset grant order starts at flow 0.
